// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: FSM state encoding,
// default preamble, CRC-8 polynomial, frame-class counts and the serial CRC step.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } cfg_state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam int         NUM_TILES         = 14;
    localparam int         NUM_SWITCHES      = 22;

    // One MSB-first serial CRC-8 step: feedback is the outgoing MSB xor the new bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 accumulator (init 0x00, MSB first) with synchronous clear and bit enable.
module cfg_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc
);

    // Clear has priority so a new load never inherits the previous remainder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (enable) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: hunts for the sync preamble, then deserialises
// NUM_FRAMES frames of FRAME_W bits (MSB first) and writes each one out with a
// single-cycle cfg_we strobe. Optional macro CFG_LOADER_CRC_EN adds a trailing
// CRC-8 byte check (CHECK state) that selects DONE or ERROR.
module config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int         NUM_FRAMES = 36,
    parameter int         FRAME_W    = 33,
    parameter logic [7:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [5:0]         cfg_addr,
    output logic [FRAME_W-1:0] cfg_data,
    output logic               cfg_we,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int               BIT_W      = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);
    localparam logic [5:0]       LAST_FRAME = 6'(NUM_FRAMES - 1);

    cfg_state_t         state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [5:0]         frame_idx;
    logic [7:0]         sync_win;
    logic [FRAME_W-1:0] frame_sh;

    logic               accept;
    logic [7:0]         win_next;
    logic [FRAME_W-1:0] frame_next;

    assign accept     = bit_valid & bit_ready;
    assign win_next   = {sync_win[6:0], bit_in};
    assign frame_next = {frame_sh[FRAME_W-2:0], bit_in};

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc;
    logic [7:0] chk_sh;
    logic [2:0] chk_cnt;
    logic       crc_clear;
    logic       crc_en;

    // A start that is honoured (loader not busy) restarts the CRC; only frame bits feed it.
    assign crc_clear = start & ~busy;
    assign crc_en    = accept & (state == LOAD);

    cfg_crc8 u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (bit_in),
        .crc    (crc)
    );
`else
    assign error = 1'b0;
`endif

    // Loader FSM; every status output is registered alongside the state change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            bit_cnt   <= '0;
            frame_idx <= '0;
            sync_win  <= '0;
            frame_sh  <= '0;
`ifdef CFG_LOADER_CRC_EN
            error     <= 1'b0;
            chk_sh    <= '0;
            chk_cnt   <= '0;
`endif
        end else begin
            cfg_we <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state     <= SYNC;
                        busy      <= 1'b1;
                        bit_ready <= 1'b1;
                        done      <= 1'b0;
                        bit_cnt   <= '0;
                        frame_idx <= '0;
                        sync_win  <= '0;
`ifdef CFG_LOADER_CRC_EN
                        error     <= 1'b0;
                        chk_cnt   <= '0;
`endif
                    end
                end
                SYNC: begin
                    if (accept) begin
                        sync_win <= win_next;
                        if (win_next == SYNC_WORD) begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        frame_sh <= frame_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            cfg_we   <= 1'b1;
                            cfg_addr <= frame_idx;
                            cfg_data <= frame_next;
                            if (frame_idx == LAST_FRAME) begin
`ifdef CFG_LOADER_CRC_EN
                                state     <= CHECK;
`else
                                state     <= DONE;
                                busy      <= 1'b0;
                                bit_ready <= 1'b0;
                                done      <= 1'b1;
`endif
                            end else begin
                                frame_idx <= frame_idx + 6'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef CFG_LOADER_CRC_EN
                CHECK: begin
                    if (accept) begin
                        chk_sh  <= {chk_sh[6:0], bit_in};
                        chk_cnt <= chk_cnt + 3'd1;
                        if (chk_cnt == 3'd7) begin
                            busy      <= 1'b0;
                            bit_ready <= 1'b0;
                            if ({chk_sh[6:0], bit_in} == crc) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ERROR;
                                error <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    bit_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: a frame-list scoreboard plus a
// polynomial-division CRC model predict every write and the final status.
module tb_config_loader;

    localparam int NFR = 36;
    localparam int FW  = 33;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic [5:0]    cfg_addr;
    logic [FW-1:0] cfg_data;
    logic          cfg_we;
    logic          busy;
    logic          done;
    logic          error;

    config_loader #(.NUM_FRAMES(NFR), .FRAME_W(FW), .SYNC_WORD(8'hA5)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_we    (cfg_we),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]    a;
        logic [FW-1:0] d;
    } wr_t;

    int        n_chk = 0;
    int        n_fail = 0;
    int        wr_cnt = 0;
    logic [5:0]    first_addr, last_addr;
    logic [FW-1:0] first_data, last_data;
    wr_t       exp_q[$];
    bit        stream[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // CRC-8 as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc_model(input bit q[$]);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < q.size() + 8; i++) begin
            r = {r[7:0], (i < q.size()) ? q[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
    endtask

    task automatic build_stream(input bit long_pre, input bit bad_crc);
        bit         fb[$];
        logic [FW-1:0] kv;
        logic [7:0] c;
        stream.delete();
        if (long_pre) begin
            push_byte(8'h5A);
            push_byte(8'hFF);
        end
        push_byte(8'hA5);
        for (int k = 0; k < NFR; k++) begin
            kv = FW'(k);
            for (int i = FW - 1; i >= 0; i--) begin
                stream.push_back(kv[i]);
                fb.push_back(kv[i]);
            end
        end
        c = crc_model(fb);
        if (bad_crc) c = c ^ 8'h01;
`ifdef CFG_LOADER_CRC_EN
        push_byte(c);
`endif
    endtask

    task automatic expect_frames(input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back({6'(k), FW'(k)});
        wr_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send(input int nbits, input int maxgap);
        int t;
        for (int i = 0; i < nbits && i < stream.size(); i++) begin
            if (maxgap > 0) begin
                int g;
                g = $urandom_range(maxgap, 0);
                bit_valid = 1'b0;
                repeat (g) begin @(posedge clock); #1; end
            end
            bit_valid = 1'b1;
            bit_in    = stream[i];
            t = 0;
            forever begin
                @(negedge clock);
                if (bit_ready) begin
                    @(posedge clock); #1;
                    break;
                end
                t++;
                if (t > 2000) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL send_timeout: bit %0d not accepted, got ready=0, required ready=1", i);
                    bit_valid = 1'b0;
                    return;
                end
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic end_check(input string tag, input int nwr, input bit exp_done, input bit exp_err);
        repeat (3) @(posedge clock);
        #1;
        chk({tag, "_writes"}, wr_cnt, nwr);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard: every cfg_we must match the next expected frame write.
    always @(negedge clock) begin
        if (!reset) begin
            chk("ready_eq_busy", bit_ready, busy);
            if (cfg_we) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_we: got write addr=%0d data=%0h, required no write", cfg_addr, cfg_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", cfg_addr, w.a);
                    chk("wr_data", cfg_data, w.d);
                end
                if (wr_cnt == 0) begin
                    first_addr = cfg_addr;
                    first_data = cfg_data;
                end
                last_addr = cfg_addr;
                last_data = cfg_data;
                wr_cnt++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish within 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit one_byte[$];
        int t;
        reset     = 1'b1;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", bit_ready, 0);
        chk("rst_we",    cfg_we,    0);
        chk("rst_addr",  cfg_addr,  0);
        chk("rst_data",  cfg_data,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_error", error,     0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Model pin: CRC-8/0x07 of byte 0x01 is 0x07.
        for (int i = 7; i >= 0; i--) one_byte.push_back(i == 0);
        chk("crc_model_pin", crc_model(one_byte), 8'h07);

        // Plain load, no stalls.
        build_stream(1'b0, 1'b0);
        expect_frames(NFR);
        pulse_start();
        chk("t1_busy_after_start", busy, 1);
        send(stream.size(), 0);
        end_check("t1", NFR, 1'b1, 1'b0);
        chk("t1_first_addr", first_addr, 0);
        chk("t1_first_data", first_data, 0);
        chk("t1_last_addr",  last_addr,  35);
        chk("t1_last_data",  last_data,  35);

        // Random bit_valid gaps 0..5.
        expect_frames(NFR);
        pulse_start();
        send(stream.size(), 5);
        end_check("t2", NFR, 1'b1, 1'b0);

        // Decoy preamble bytes before the sync word.
        build_stream(1'b1, 1'b0);
        expect_frames(NFR);
        pulse_start();
        send(stream.size(), 0);
        end_check("t3", NFR, 1'b1, 1'b0);
        chk("t3_first_addr", first_addr, 0);

        // Start pulsed while loading frame 5 must be ignored.
        build_stream(1'b0, 1'b0);
        expect_frames(NFR);
        pulse_start();
        fork
            send(stream.size(), 0);
            begin
                t = 0;
                while (wr_cnt < 5 && t < 5000) begin
                    @(posedge clock);
                    t++;
                end
                #1;
                if (wr_cnt < 5) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL t5_wait: got %0d writes, required 5", wr_cnt);
                end else begin
                    pulse_start();
                end
            end
        join
        end_check("t5", NFR, 1'b1, 1'b0);

        // Reset in the middle of frame 10.
        expect_frames(10);
        pulse_start();
        send(8 + 10 * FW + 15, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_rst_we",    cfg_we,    0);
        chk("t4_rst_addr",  cfg_addr,  0);
        chk("t4_rst_data",  cfg_data,  0);
        chk("t4_rst_busy",  busy,      0);
        chk("t4_rst_ready", bit_ready, 0);
        chk("t4_rst_done",  done,      0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("t4_writes_before_reset", wr_cnt, 10);
        chk("t4_idle_busy", busy, 0);
        expect_frames(NFR);
        pulse_start();
        send(stream.size(), 0);
        end_check("t4_reload", NFR, 1'b1, 1'b0);
        chk("t4_reload_first_addr", first_addr, 0);

`ifdef CFG_LOADER_CRC_EN
        // Corrupted CRC byte ends in ERROR.
        build_stream(1'b0, 1'b1);
        expect_frames(NFR);
        pulse_start();
        send(stream.size(), 0);
        end_check("t6", NFR, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 36, meaning frame count: 14 logic tiles followed by 22 switch boxes.
REQ-002 SHALL have parameter FRAME_W, default 33, meaning bits per frame; logic tile uses [32:0], switch box uses [15:0].
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5, meaning preamble preceding frame data.
REQ-004 SHALL have port clock, input, width 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, width 1: one-cycle request to begin a load.
REQ-007 SHALL have port bit_in, input, width 1: serial bitstream, MSB first.
REQ-008 SHALL have port bit_valid, input, width 1: bit_in is valid this cycle.
REQ-009 SHALL have port bit_ready, output, width 1: loader accepts a bit this cycle.
REQ-010 SHALL have port cfg_addr, output, width 6: target frame index.
REQ-011 SHALL have port cfg_data, output, width FRAME_W: frame contents.
REQ-012 SHALL have port cfg_we, output, width 1: one-cycle write strobe for cfg_addr/cfg_data.
REQ-013 SHALL have port busy, done and error, each output, width 1: status flags.

Function
REQ-014 SHALL implement states IDLE, SYNC, LOAD, CHECK, DONE and ERROR.
REQ-015 SHALL count a bit as accepted only on a cycle where bit_valid and bit_ready are both high.
REQ-016 SHALL drive bit_ready high only in SYNC, LOAD and CHECK.
REQ-017 SHALL move from IDLE, DONE or ERROR to SYNC on start, clearing done, error, frame counter and bit counter.
REQ-018 SHALL ignore start while busy (SYNC, LOAD or CHECK).
REQ-019 SHALL, in SYNC, compare a sliding 8-bit window of accepted bits with SYNC_WORD and move to LOAD on the first-cycle match.
REQ-020 SHALL, in LOAD, shift accepted bits into a FRAME_W register.
REQ-021 SHALL, on the FRAME_W-th accepted bit of a frame, assert cfg_we for exactly one cycle in the following cycle, with cfg_addr equal to the frame index and cfg_data equal to the full frame (latency 1).
REQ-022 SHALL hold cfg_addr and cfg_data stable until the next write.
REQ-023 SHALL increment the frame index after each write and never wrap; the last frame index is NUM_FRAMES-1.
REQ-024 SHALL leave LOAD after the last frame to CHECK when the macro is defined, otherwise to DONE.
REQ-025 SHALL keep done high in DONE and error high in ERROR; both are sticky until start or reset.
REQ-026 SHALL assert busy exactly in SYNC, LOAD and CHECK.
REQ-027 SHALL allow stalls: bit_valid low for any number of cycles does not alter state or counters.

Reset
REQ-028 SHALL, on reset, enter IDLE and set bit_ready=0, cfg_we=0, cfg_addr=0, cfg_data=0, busy=0, done=0, error=0, counters=0, CRC=0.
REQ-029 SHALL, on reset mid-load, abort immediately and issue no further cfg_we; frames already written remain the consumer's responsibility.

Configuration
REQ-030 SHALL, with CFG_LOADER_CRC_EN defined, run CRC-8 (poly 0x07, init 0x00, serial, MSB first) over all frame bits, then in CHECK accept 8 CRC bits and go to DONE on match or ERROR on mismatch.
REQ-031 SHALL, without CFG_LOADER_CRC_EN, omit the CHECK state and CRC logic; error is then constant 0.

Structure
REQ-032 SHALL place the state enumeration, SYNC_WORD default, CRC polynomial, NUM_TILES=14 and NUM_SWITCHES=22 in shared package fpga_cfg_pkg.
REQ-033 SHALL implement the CRC as one sub-module, cfg_crc8 (serial update, clear, enable).

Verification
REQ-034 Stimulus: reset, start, then bits 8'hA5 followed by 36 frames where frame k = k. Required response: 36 cfg_we pulses with addr k and data k, then done=1 and busy=0.
REQ-035 Stimulus: random bit_valid gaps of 0-5 cycles on the same stream. Required response: identical writes; no extra or missing cfg_we.
REQ-036 Stimulus: preamble 8'h5A, 8'hFF, then 8'hA5. Required response: stays in SYNC until 8'hA5 completes; first write is addr 0.
REQ-037 Stimulus: reset asserted during frame 10. Required response: all outputs take reset values immediately; no cfg_we after reset; a new start reloads from addr 0.
REQ-038 Stimulus (CFG_LOADER_CRC_EN): correct CRC, then a CRC with one bit flipped. Required response: done=1 in the first case; error=1 and done=0 in the second.
REQ-039 Stimulus: start pulsed during LOAD at frame 5. Required response: ignored; the load completes normally.
